// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, pixel record and {y,x} address packing.
// Used by both the title-page drawer (write side) and fb_scan_reader (read side).
package fb_pkg;

  localparam int FB_WIDTH    = 160;
  localparam int FB_HEIGHT   = 120;
  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 7;
  localparam int COLOUR_BITS = 3;
  localparam int ADDR_BITS   = X_BITS + Y_BITS;

  typedef struct packed {
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      y;
    logic [COLOUR_BITS-1:0] colour;
    logic                   last;
  } fb_pixel_t;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_RUN   = 2'd1,
    SCAN_DRAIN = 2'd2
  } fb_scan_state_e;

  function automatic logic [ADDR_BITS-1:0] fb_pack_addr(input logic [X_BITS-1:0] x,
                                                        input logic [Y_BITS-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_skid_fifo2.sv
// Two-entry FIFO with occupancy output; the head entry is visible on data_o whenever valid_o.
// Handshake: an entry is written when push_i, removed when pop_i && valid_o.
module fb_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  // The producer's issue throttle makes a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push_i |-> (count_q != 2'd2));

endmodule

// File: rtl/fb_scan_reader.sv
// Raster-order framebuffer reader: hides the RAM's 1-cycle read latency behind a 2-entry buffer.
// Optional FB_SCAN_SKIP_BLACK_EN: colour-0 pixels are dropped internally and never presented.
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  output logic [ADDR_BITS-1:0]   rd_addr,
  input  logic [COLOUR_BITS-1:0] rd_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [X_BITS-1:0]      pix_x,
  output logic [Y_BITS-1:0]      pix_y,
  output logic [COLOUR_BITS-1:0] pix_colour,
  output logic                   pix_last,
  output logic                   busy,
  output logic                   done
);

  fb_scan_state_e    state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              inflight_q;
  logic [X_BITS-1:0] tag_x_q;
  logic [Y_BITS-1:0] tag_y_q;
  logic              tag_last_q;

  fb_pixel_t  push_pix;
  fb_pixel_t  head;
  logic       fifo_valid;
  logic       fifo_pop;
  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  logic       pix_show;
  logic       issue;
  logic       at_last;
  logic       drained;
  logic       busy_c;
  logic       done_c;

  assign push_pix = '{x: tag_x_q, y: tag_y_q, colour: rd_data, last: tag_last_q};

  fb_skid_fifo2 #(.W($bits(fb_pixel_t))) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (inflight_q),
    .data_i  (push_pix),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

`ifdef FB_SCAN_SKIP_BLACK_EN
  assign pix_show = fifo_valid && (head.colour != '0);
  assign fifo_pop = fifo_valid && ((head.colour == '0) || pix_ready);
`else
  assign pix_show = fifo_valid;
  assign fifo_pop = fifo_valid && pix_ready;
`endif

  // Buffered plus in-flight entries, less this cycle's pop, must leave room for one more.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue     = (state_q == SCAN_RUN) && (occupancy < (3'd2 + {2'b00, fifo_pop}));
  assign at_last   = (x_q == X_BITS'(WIDTH - 1)) && (y_q == Y_BITS'(HEIGHT - 1));
  assign drained   = !inflight_q && (fifo_count == 2'd0);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (start) begin
          state_d = SCAN_RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN_RUN: begin
        busy_c = 1'b1;
        if (issue) begin
          if (at_last) begin
            state_d = SCAN_DRAIN;
          end else if (x_q == X_BITS'(WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + Y_BITS'(1);
          end else begin
            x_d = x_q + X_BITS'(1);
          end
        end
      end
      SCAN_DRAIN: begin
        if (drained) begin
          done_c  = 1'b1;
          state_d = SCAN_IDLE;
        end else begin
          busy_c = 1'b1;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SCAN_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_x_q    <= '0;
      tag_y_q    <= '0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= issue;
      if (issue) begin
        tag_x_q    <= x_q;
        tag_y_q    <= y_q;
        tag_last_q <= at_last;
      end
    end
  end

  assign rd_addr    = fb_pack_addr(x_q, y_q);
  assign pix_valid  = pix_show;
  assign pix_x      = head.x;
  assign pix_y      = head.y;
  assign pix_colour = head.colour;
  assign pix_last   = pix_show && head.last;
  assign busy       = busy_c;
  assign done       = done_c;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: synchronous RAM fixture, raster-order expected queue, per-cycle compare.
`timescale 1ns/1ps
module tb_fb_scan_reader;
  import fb_pkg::*;

  typedef logic [18:0] pix_t; // {x, y, colour, last}

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data = 3'd0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;
  logic        pix_last;
  logic        busy;
  logic        done;

  logic [2:0] ram [0:32767];
  pix_t       exp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_count = 0;
  int   done_count = 0;
  int   cyc = 0;
  int   last_hs_cyc = 0;
  int   wrap_seen = 0;
  int   exp_total = 0;
  bit   last_hs_last = 1'b0;
  bit   stall_prev = 1'b0;
  bit   rand_ready = 1'b0;
  pix_t held = '0;
  logic [14:0] prev_addr = '0;

  fb_scan_reader dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_last   (pix_last),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock / RAM fixture ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= ram[rd_addr];

  initial begin
    forever begin
      @(posedge clk);
      #1 pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic fill_ram(input int mode);
    for (int a = 0; a < 32768; a++) ram[a] = 3'd0;
    if (mode == 2) begin
      ram[10 * 256 + 10] = 3'b101;
    end else begin
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++)
          ram[y * 256 + x] = (mode == 0) ? 3'((x + y) % 8) : 3'($urandom_range(0, 7));
    end
  endtask

  task automatic build_expected();
    logic [2:0] c;
    exp_q.delete();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        c = ram[y * 256 + x];
`ifdef FB_SCAN_SKIP_BLACK_EN
        if (c == 3'd0) continue;
`endif
        exp_q.push_back({8'(x), 7'(y), c, (x == 159 && y == 119)});
      end
    exp_total = exp_q.size();
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    pix_t cur;
    cur = {pix_x, pix_y, pix_colour, pix_last};
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("pix_hold_valid", 32'(pix_valid), 32'd1);
        check("pix_hold_fields", 32'(cur), 32'(held));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pix_extra actual=%0h required=no_pixel", cur);
        end else begin
          check("pix", 32'(cur), 32'(exp_q.pop_front()));
        end
        hs_count++;
        last_hs_cyc  = cyc;
        last_hs_last = pix_last;
      end
      stall_prev = pix_valid && !pix_ready;
      held       = cur;
      if (done) begin
        done_count++;
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        if (last_hs_last) check("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
        last_hs_last = 1'b0;
      end
      if (rd_addr != prev_addr) begin
        if (prev_addr == 15'h009F) begin
          check("row_wrap_addr", 32'(rd_addr), 32'h0100);
          wrap_seen++;
        end
        prev_addr = rd_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_addr"}, 32'(rd_addr), 32'd0);
    check({name, "_outs"}, 32'({pix_valid, pix_x, pix_y, pix_colour, pix_last, busy, done}), 32'd0);
  endtask

  task automatic frame_end_checks(input string name);
    repeat (20) @(negedge clk);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
    check({name, "_valid_idle"}, 32'(pix_valid), 32'd0);
    check({name, "_done_count"}, 32'(done_count), 32'd1);
    check({name, "_hs_count"}, 32'(hs_count), 32'(exp_total));
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    n_errors++;
    $display("FAIL watchdog cycle budget exhausted");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    fill_ram(0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;

    // Frame A: ready held high, colour=(x+y)%8, start while busy and start with done.
    build_expected();
`ifndef FB_SCAN_SKIP_BLACK_EN
    check("model_pix_159_0", 32'(exp_q[159]), 32'({8'd159, 7'd0, 3'd7, 1'b0}));
    check("model_pix_0_1", 32'(exp_q[160]), 32'({8'd0, 7'd1, 3'd1, 1'b0}));
    check("model_last", 32'(exp_q[19199]), 32'({8'd159, 7'd119, 3'd6, 1'b1}));
    check("model_total", 32'(exp_total), 32'd19200);
`endif
    hs_count = 0;
    done_count = 0;
    pulse_start();
    @(negedge clk);
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_valid", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_valid", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("lat_c3_valid", 32'(pix_valid), 32'd1);
    check("first_pix_xy", 32'({pix_x, pix_y}), 32'd0);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(30000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    frame_end_checks("frame_a");

    // Frame B: random data, random ready, reset asserted at handshake 5000.
    rand_ready = 1'b1;
    fill_ram(1);
    build_expected();
    hs_count = 0;
    done_count = 0;
    pulse_start();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (hs_count >= 5000 && pix_valid) break;
    end
    check("mid_reset_reached", 32'(pix_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    check("mid_reset_no_done", 32'(done_count), 32'd0);

    // Frame C: fresh frame after the aborted one, random ready.
    fill_ram(1);
    build_expected();
    hs_count = 0;
    done_count = 0;
    pulse_start();
    wait_done(60000);
    frame_end_checks("frame_c");

`ifdef FB_SCAN_SKIP_BLACK_EN
    // Frame D: only one non-black pixel; final pixel is black.
    rand_ready = 1'b0;
    fill_ram(2);
    build_expected();
    check("skip_model_total", 32'(exp_total), 32'd1);
    hs_count = 0;
    done_count = 0;
    pulse_start();
    wait_done(30000);
    frame_end_checks("frame_d");
`endif

    check("row_wrap_seen", 32'(wrap_seen >= 3), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
